updn_counter_n: RTL

UPDN_COUNTER_N -- requirements
Module: updn_counter_n

---
 rtl/updn_pkg.sv | 11 +
 rtl/cnt_tff_cell.sv | 21 ++
 rtl/updn_counter_n.sv | 82 ++++++++
 3 files changed

// File: rtl/updn_pkg.sv
// Shared types and limits for the up/down counter slice.
package updn_pkg;

    typedef enum logic {
        CNT_WRAP,
        CNT_SAT
    } cnt_mode_e;

    localparam int unsigned CNT_MAX_WIDTH = 32;

endpackage

// File: rtl/cnt_tff_cell.sv
// Single counter bit: T flip-flop with async active-high reset and synchronous load override.
module cnt_tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/updn_counter_n.sv
// Up/down counter over 0..max_val with wrap or saturate policy, built from T flip-flop cells.
// Optional parallel load is enabled by defining UPDN_COUNTER_LOAD_EN.
module updn_counter_n
    import updn_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter cnt_mode_e   MODE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] max_val,
`ifdef UPDN_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap_p
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] tgl;

`ifdef UPDN_COUNTER_LOAD_EN
    assign ld     = load;
    assign ld_val = load_val;
`else
    assign ld     = 1'b0;
    assign ld_val = '0;
`endif

    // Full next value is resolved here; cells only see which bits must flip.
    always_comb begin
        nxt = out;
        if (en) begin
            if (!down) begin
                if (out >= max_val) begin
                    nxt = (MODE == CNT_SAT) ? max_val : '0;
                end else begin
                    nxt = out + ONE;
                end
            end else begin
                if (out > max_val) begin
                    nxt = max_val;
                end else if (out == '0) begin
                    nxt = (MODE == CNT_SAT) ? '0 : max_val;
                end else begin
                    nxt = out - ONE;
                end
            end
        end
    end

    assign tgl = out ^ nxt;
    assign tc  = en & ((~down & (out >= max_val)) | (down & (out == '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_p <= 1'b0;
        end else begin
            wrap_p <= tc & ~ld;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cnt_tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (tgl[i]),
            .ld  (ld),
            .d   (ld_val[i]),
            .q   (out[i])
        );
    end

endmodule
